hwpe_stream_tcdm_fifo_rw: RTL

HWPE_STREAM_TCDM_FIFO_RW -- requirements
Module: hwpe_stream_tcdm_fifo_rw

---
 rtl/hwpe_stream_tcdm_fifo_rw.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hwpe_stream_tcdm_fifo_rw.sv
// Request FIFO between a TCDM slave port and a TCDM master port. It caps the number
// of loads in flight on the master side and passes load responses straight through.
module hwpe_stream_tcdm_fifo_rw #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  input  logic                                 slv_req_i,
  output logic                                 slv_gnt_o,
  input  logic [ADDR_WIDTH-1:0]                slv_add_i,
  input  logic                                 slv_wen_i,
  input  logic [DATA_WIDTH/8-1:0]              slv_be_i,
  input  logic [DATA_WIDTH-1:0]                slv_data_i,
  output logic [DATA_WIDTH-1:0]                slv_r_data_o,
  output logic                                 slv_r_valid_o,
  output logic                                 mst_req_o,
  input  logic                                 mst_gnt_i,
  output logic [ADDR_WIDTH-1:0]                mst_add_o,
  output logic                                 mst_wen_o,
  output logic [DATA_WIDTH/8-1:0]              mst_be_o,
  output logic [DATA_WIDTH-1:0]                mst_data_o,
  input  logic [DATA_WIDTH-1:0]                mst_r_data_i,
  input  logic                                 mst_r_valid_i,
  output logic [$clog2(FIFO_DEPTH):0]          occupancy_o,
  output logic                                 empty_o,
  output logic                                 full_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int EW = 1 + BW + DATA_WIDTH + ADDR_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUTSTANDING);

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [OW-1:0] outst_reg;

  logic [EW-1:0] head;
  logic          head_wen;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          at_limit;
  logic          mst_req;
  logic          load_issue;
  logic          resp_ret;

  assign head     = mem[rd_ptr_reg];
  assign head_wen = head[EW-1];
  assign empty    = (count_reg == '0);
  assign full     = (count_reg == DEPTH_C);
  assign at_limit = (outst_reg == MAX_OUT_C);
  assign push     = slv_req_i && !full;
  // A load at the head that hits the limit stalls everything behind it to keep order.
  assign mst_req  = !empty && !(head_wen && at_limit);
  assign pop      = mst_req && mst_gnt_i;

  assign load_issue = pop && head_wen;
  assign resp_ret   = mst_r_valid_i && (outst_reg != '0);

  // Storage is not reset; its contents only matter once occupancy covers them.
  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_i) begin
        if (push && (wr_ptr_reg == PW'(gi))) begin
          mem[gi] <= {slv_wen_i, slv_be_i, slv_data_i, slv_add_i};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Flushing the queue leaves this alone: issued loads still owe a response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      outst_reg <= '0;
    end else if (load_issue && !resp_ret) begin
      outst_reg <= outst_reg + OW'(1);
    end else if (resp_ret && !load_issue) begin
      outst_reg <= outst_reg - OW'(1);
    end
  end

  assign slv_gnt_o     = !full;
  assign mst_req_o     = mst_req;
  assign mst_add_o     = head[ADDR_WIDTH-1:0];
  assign mst_data_o    = head[ADDR_WIDTH +: DATA_WIDTH];
  assign mst_be_o      = head[ADDR_WIDTH+DATA_WIDTH +: BW];
  assign mst_wen_o     = head_wen;
  assign slv_r_valid_o = mst_r_valid_i;
  assign slv_r_data_o  = mst_r_data_i;
  assign occupancy_o   = count_reg;
  assign empty_o       = empty;
  assign full_o        = full;
  assign outstanding_o = outst_reg;

endmodule
